// File: rtl/mux_mac_pkg.sv
// mux_mac_pkg
// Shared definitions for the mux_mac operand-select arithmetic unit.
//   - 2-bit operation encodings and the op_t enum built on them
//   - state_t enum for the request/execute/hold controller
package mux_mac_pkg;

   localparam logic [1:0] OP_ADD_ENC = 2'b00;
   localparam logic [1:0] OP_MUL_ENC = 2'b01;
   localparam logic [1:0] OP_MAC_ENC = 2'b10;
   localparam logic [1:0] OP_CLR_ENC = 2'b11;

   typedef enum logic [1:0] {
      OP_ADD = OP_ADD_ENC,
      OP_MUL = OP_MUL_ENC,
      OP_MAC = OP_MAC_ENC,
      OP_CLR = OP_CLR_ENC
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/mux_mac_channel_mux.sv
// channel_mux
// Purely combinational N-to-1 channel selector.
// Ports:
//   sel     - channel index; any index >= CHANNELS selects a zero operand
//   ch_data - packed channels, channel i = ch_data[i*WIDTH +: WIDTH]
//   data    - selected channel
module channel_mux #(
   parameter int CHANNELS = 4,
   parameter int WIDTH = 8,
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic [SELW-1:0]           sel,
   input  logic [CHANNELS*WIDTH-1:0] ch_data,
   output logic [WIDTH-1:0]          data
);

   // Compare against every real channel; when CHANNELS is not a power of
   // two the spare select codes match nothing and the zero default stands.
   always_comb begin
      data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(sel) == i) begin
            data = ch_data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_mac.sv
// mux_mac
// Operand-select add / multiply / multiply-accumulate unit with a persistent
// accumulator, optional saturation and valid/ready handshakes on both sides.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   - request handshake (in_ready only in IDLE)
//   sel_a, sel_b         - channel indices for operands A and B
//   ch_data              - packed input channels
//   op                   - 00 ADD, 01 MUL, 10 MAC, 11 CLR
//   out_valid, out_ready - result handshake (out_valid only in HOLD)
//   result               - registered operation result
//   overflow             - sticky accumulator overflow, cleared by CLR/reset
module mux_mac
   import mux_mac_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHANNELS = 4,
   parameter int ACC_WIDTH = 20,
   parameter bit SAT = 1'b1,
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SELW-1:0]           sel_a,
   input  logic [SELW-1:0]           sel_b,
   input  logic [CHANNELS*WIDTH-1:0] ch_data,
   input  logic [1:0]                op,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_WIDTH-1:0]      result,
   output logic                      overflow
);

   if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc_width
      $error("mux_mac: ACC_WIDTH must be at least 2*WIDTH");
   end
   if (CHANNELS < 2) begin : g_bad_channels
      $error("mux_mac: CHANNELS must be at least 2");
   end

   state_t                 state_q;
   state_t                 state_d;
   logic [WIDTH-1:0]       mux_a;
   logic [WIDTH-1:0]       mux_b;
   logic [WIDTH-1:0]       opa_q;
   logic [WIDTH-1:0]       opb_q;
   op_t                    op_q;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [ACC_WIDTH-1:0]   result_q;
   logic                   overflow_q;
   logic                   accept;
   logic [WIDTH:0]         add_sum;
   logic [2*WIDTH-1:0]     product;
   logic [ACC_WIDTH:0]     mac_sum;
   logic                   mac_ovf;
   logic [ACC_WIDTH-1:0]   mac_acc;

   channel_mux #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) u_mux_a (
      .sel     (sel_a),
      .ch_data (ch_data),
      .data    (mux_a)
   );

   channel_mux #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) u_mux_b (
      .sel     (sel_b),
      .ch_data (ch_data),
      .data    (mux_b)
   );

   // in_ready is gated by reset so nothing can look accepted on a reset edge.
   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid && in_ready;
   assign result    = result_q;
   assign overflow  = overflow_q;

   // Arithmetic runs on the captured operands only, so ch_data may change
   // freely once a request has been accepted. The MAC sum carries one extra
   // bit so that its top bit is the overflow indication.
   assign add_sum = (WIDTH+1)'(opa_q) + (WIDTH+1)'(opb_q);
   assign product = (2*WIDTH)'(opa_q) * (2*WIDTH)'(opb_q);
   assign mac_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(product);
   assign mac_ovf = mac_sum[ACC_WIDTH];

   // Saturating builds pin the accumulator at all-ones; once there, any
   // further nonzero product overflows again and it stays pinned.
   always_comb begin
      mac_acc = mac_sum[ACC_WIDTH-1:0];
      if (mac_ovf && SAT) begin
         mac_acc = '1;
      end
   end

   // Controller: IDLE accepts, EXEC is the single compute cycle, HOLD keeps
   // the result presented until the consumer takes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons whatever request is in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture at acceptance, then result/accumulator update in EXEC.
   // ADD and MUL leave acc and overflow untouched; CLR wipes all three.
   always_ff @(posedge clock) begin
      if (reset) begin
         opa_q      <= '0;
         opb_q      <= '0;
         op_q       <= OP_ADD;
         acc_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            opa_q <= mux_a;
            opb_q <= mux_b;
            op_q  <= op_t'(op);
         end
         if (state_q == EXEC) begin
            case (op_q)
               OP_ADD: result_q <= ACC_WIDTH'(add_sum);
               OP_MUL: result_q <= ACC_WIDTH'(product);
               OP_MAC: begin
                  acc_q    <= mac_acc;
                  result_q <= mac_acc;
                  if (mac_ovf) begin
                     overflow_q <= 1'b1;
                  end
               end
               OP_CLR: begin
                  acc_q      <= '0;
                  result_q   <= '0;
                  overflow_q <= 1'b0;
               end
               default: result_q <= result_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mux_mac.sv
// tb_mux_mac
// Scoreboard bench for mux_mac. Three instances:
//   dut 0 - defaults (WIDTH=8, CHANNELS=4, ACC_WIDTH=20, SAT=1)
//   dut 1 - SAT=0, wrapping accumulator
//   dut 2 - CHANNELS=3, exercising the out-of-range select
// Requests push their hand-computed expected result into a per-instance
// queue; a negedge monitor pops and compares on every result handshake.
module tb_mux_mac;
   import mux_mac_pkg::*;

   typedef struct packed {
      logic [19:0] res;
      logic        ovf;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [1:0]  sel_a     [3];
   logic [1:0]  sel_b     [3];
   logic [31:0] ch_data   [3];
   logic [1:0]  op        [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [19:0] result    [3];
   logic        overflow  [3];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int checks = 0;
   int failures = 0;

   logic        prev_hold [3];
   logic [19:0] prev_res  [3];

   always #5 clock = ~clock;

   mux_mac #(.WIDTH(8), .CHANNELS(4), .ACC_WIDTH(20), .SAT(1'b1)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .sel_a(sel_a[0]), .sel_b(sel_b[0]), .ch_data(ch_data[0]), .op(op[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
      .overflow(overflow[0])
   );

   mux_mac #(.WIDTH(8), .CHANNELS(4), .ACC_WIDTH(20), .SAT(1'b0)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .sel_a(sel_a[1]), .sel_b(sel_b[1]), .ch_data(ch_data[1]), .op(op[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
      .overflow(overflow[1])
   );

   mux_mac #(.WIDTH(8), .CHANNELS(3), .ACC_WIDTH(20), .SAT(1'b1)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .sel_a(sel_a[2]), .sel_b(sel_b[2]), .ch_data(ch_data[2][23:0]), .op(op[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(result[2]),
      .overflow(overflow[2])
   );

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic pushExpected(input int d, input logic [19:0] res, input logic ovf);
      exp_t e;
      e.res = res;
      e.ovf = ovf;
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Pops the oldest expectation for instance d and compares it with what
   // the DUT is presenting; an output with nothing expected is itself a fault.
   task automatic checkOutput(input int d);
      exp_t e;
      bit   empty;
      empty = 1'b0;
      e = '0;
      case (d)
         0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
         1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
         default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
      endcase
      if (empty) begin
         checks++;
         failures++;
         $display("[TB] FAIL dut%0d_unexpected_output: got result %0d, required no output", d, result[d]);
      end else begin
         checkValue($sformatf("dut%0d_result", d), 32'(result[d]), 32'(e.res));
         checkValue($sformatf("dut%0d_overflow", d), 32'(overflow[d]), 32'(e.ovf));
      end
   endtask

   // Monitor: compares on each result handshake and checks that a held
   // result does not move while the consumer applies backpressure.
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            if (prev_hold[i] && out_valid[i]) begin
               checkValue($sformatf("dut%0d_held_result_stable", i), 32'(result[i]), 32'(prev_res[i]));
            end
            if (out_valid[i] && out_ready[i]) begin
               checkOutput(i);
            end
            prev_hold[i] = out_valid[i] && !out_ready[i];
            prev_res[i]  = result[i];
         end else begin
            prev_hold[i] = 1'b0;
         end
      end
   end

   // Issues one request to instance d (entered just after a rising edge),
   // records its expectation and checks the EXEC/HOLD timing. With
   // wait_done set it also waits, bounded, for the result to be taken.
   task automatic applyStimulus(input int d, input logic [1:0] o, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [31:0] data,
                                input logic [19:0] eres, input logic eovf, input bit wait_done);
      int n;
      n = 0;
      while (!in_ready[d] && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready[d]) begin
         checkValue($sformatf("dut%0d_accept_timeout", d), 32'(in_ready[d]), 32'd1);
         return;
      end
      in_valid[d] = 1'b1;
      op[d]       = o;
      sel_a[d]    = sa;
      sel_b[d]    = sb;
      ch_data[d]  = data;
      pushExpected(d, eres, eovf);
      @(posedge clock); #1;
      in_valid[d] = 1'b0;
      ch_data[d]  = ~data;
      @(negedge clock);
      checkValue($sformatf("dut%0d_exec_out_valid", d), 32'(out_valid[d]), 32'd0);
      checkValue($sformatf("dut%0d_exec_in_ready", d), 32'(in_ready[d]), 32'd0);
      @(posedge clock); #1;
      checkValue($sformatf("dut%0d_hold_out_valid", d), 32'(out_valid[d]), 32'd1);
      if (wait_done) begin
         n = 0;
         while (out_valid[d] && n < 50) begin
            @(posedge clock); #1;
            n++;
         end
         if (out_valid[d]) begin
            checkValue($sformatf("dut%0d_done_timeout", d), 32'(out_valid[d]), 32'd0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         sel_a[i]     = 2'd0;
         sel_b[i]     = 2'd0;
         ch_data[i]   = 32'd0;
         op[i]        = OP_ADD;
         out_ready[i] = 1'b1;
         prev_hold[i] = 1'b0;
         prev_res[i]  = 20'd0;
      end

      // Reset held for two edges, then released
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkValue($sformatf("dut%0d_reset_in_ready", i), 32'(in_ready[i]), 32'd0);
         checkValue($sformatf("dut%0d_reset_out_valid", i), 32'(out_valid[i]), 32'd0);
         checkValue($sformatf("dut%0d_reset_result", i), 32'(result[i]), 32'd0);
         checkValue($sformatf("dut%0d_reset_overflow", i), 32'(overflow[i]), 32'd0);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
         checkValue($sformatf("dut%0d_post_reset_in_ready", i), 32'(in_ready[i]), 32'd1);
      end

      // ADD: ch1=200 + ch3=100 = 300
      applyStimulus(0, OP_ADD, 2'd1, 2'd3, {8'd100, 8'd0, 8'd200, 8'd0}, 20'd300, 1'b0, 1'b1);
      checkValue("dut0_add_in_ready_back", 32'(in_ready[0]), 32'd1);

      // MAC 255*255 x18 with saturation: 16th = 1040400, then pinned at 1048575
      for (int k = 1; k <= 18; k++) begin
         if (k <= 16) applyStimulus(0, OP_MAC, 2'd0, 2'd0, 32'h0000_00FF, 20'(k * 65025), 1'b0, 1'b1);
         else         applyStimulus(0, OP_MAC, 2'd0, 2'd0, 32'h0000_00FF, 20'd1048575, 1'b1, 1'b1);
      end

      // Backpressure: MUL ch2=12 * ch1=10 = 120, overflow still sticky
      out_ready[0] = 1'b0;
      applyStimulus(0, OP_MUL, 2'd2, 2'd1, {8'd0, 8'd12, 8'd10, 8'd0}, 20'd120, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         in_valid[0] = ~in_valid[0];
         ch_data[0]  = $urandom;
         @(negedge clock);
         checkValue("dut0_backpressure_in_ready", 32'(in_ready[0]), 32'd0);
         checkValue("dut0_backpressure_out_valid", 32'(out_valid[0]), 32'd1);
         @(posedge clock); #1;
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      n = 0;
      while (out_valid[0] && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      repeat (4) @(posedge clock);
      #1;
      checkValue("dut0_no_extra_output", 32'(out_valid[0]), 32'd0);

      // CLR after overflow
      applyStimulus(0, OP_CLR, 2'd0, 2'd0, 32'd0, 20'd0, 1'b0, 1'b1);

      // Build acc=500 (20*25), then reset during EXEC of another MAC
      applyStimulus(0, OP_MAC, 2'd0, 2'd1, {8'd0, 8'd0, 8'd25, 8'd20}, 20'd500, 1'b0, 1'b1);
      in_valid[0] = 1'b1;
      op[0]       = OP_MAC;
      sel_a[0]    = 2'd0;
      sel_b[0]    = 2'd1;
      ch_data[0]  = {8'd0, 8'd0, 8'd25, 8'd20};
      @(posedge clock); #1;
      in_valid[0] = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      checkValue("dut0_abort_out_valid", 32'(out_valid[0]), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkValue("dut0_abort_no_late_output", 32'(out_valid[0]), 32'd0);
      // acc was cleared, so 2*3 gives exactly 6
      applyStimulus(0, OP_MAC, 2'd2, 2'd3, {8'd3, 8'd2, 8'd0, 8'd0}, 20'd6, 1'b0, 1'b1);

      // Wrapping instance: 17th MAC wraps to 1105425 - 1048576 = 56849
      for (int k = 1; k <= 17; k++) begin
         if (k <= 16) applyStimulus(1, OP_MAC, 2'd0, 2'd0, 32'h0000_00FF, 20'(k * 65025), 1'b0, 1'b1);
         else         applyStimulus(1, OP_MAC, 2'd0, 2'd0, 32'h0000_00FF, 20'd56849, 1'b1, 1'b1);
      end
      applyStimulus(1, OP_CLR, 2'd0, 2'd0, 32'd0, 20'd0, 1'b0, 1'b1);

      // Three-channel instance: select 3 is out of range -> 0 * 7 = 0
      applyStimulus(2, OP_MUL, 2'd3, 2'd0, {8'd0, 8'd5, 8'd0, 8'd7}, 20'd0, 1'b0, 1'b1);
      applyStimulus(2, OP_MUL, 2'd2, 2'd0, {8'd0, 8'd5, 8'd0, 8'd7}, 20'd35, 1'b0, 1'b1);

      repeat (3) @(posedge clock);
      #1;
      checkValue("dut0_queue_drained", 32'(q0.size()), 32'd0);
      checkValue("dut1_queue_drained", 32'(q1.size()), 32'd0);
      checkValue("dut2_queue_drained", 32'(q2.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
